// File: rtl/regfile_sequencer_pkg.sv
// Shared constants for the register-file sequencer: opcodes, FSM state codes
// and instruction field positions.
package ctrl_pkg;

    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_SUB  = 2'b01;
    localparam logic [1:0] OP_NAND = 2'b10;
    localparam logic [1:0] OP_LDI  = 2'b11;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_READ  = 2'd1;
    localparam logic [1:0] ST_EXEC  = 2'd2;
    localparam logic [1:0] ST_WRITE = 2'd3;

    // instr = {op[7:6], rd[5:4], ra[3:2], rb[1:0]}; LDI reuses the low nibble as imm
    localparam int OP_MSB  = 7;
    localparam int OP_LSB  = 6;
    localparam int RD_MSB  = 5;
    localparam int RD_LSB  = 4;
    localparam int RA_MSB  = 3;
    localparam int RA_LSB  = 2;
    localparam int RB_MSB  = 1;
    localparam int RB_LSB  = 0;
    localparam int IMM_MSB = 3;
    localparam int IMM_LSB = 0;

endpackage

// File: rtl/regfile_sequencer_alu4.sv
// Combinational ALU for the sequencer: ADD/SUB/NAND with carry and zero flags.
module alu4
    import ctrl_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] opa,
    input  logic [WIDTH-1:0] opb,
    input  logic [1:0]       op,
    output logic [WIDTH-1:0] res,
    output logic             carry,
    output logic             zero
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] diff;

    always_comb begin
        sum   = {1'b0, opa} + {1'b0, opb};
        diff  = {1'b0, opa} - {1'b0, opb};
        res   = '0;
        carry = 1'b0;
        case (op)
            OP_ADD: begin
                res   = sum[WIDTH-1:0];
                carry = sum[WIDTH];
            end
            OP_SUB: begin
                // top bit of the extended difference is the borrow
                res   = diff[WIDTH-1:0];
                carry = ~diff[WIDTH];
            end
            OP_NAND: res = ~(opa & opb);
            default: ;
        endcase
        zero = (res == '0);
    end

endmodule

// File: rtl/regfile_sequencer.sv
// Instruction sequencer driving the register-file ports: IDLE -> READ -> EXEC -> WRITE,
// with LDI jumping straight from IDLE to WRITE.
module regfile_sequencer
    import ctrl_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int SELW  = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             instr_valid,
    output logic             instr_ready,
    input  logic [7:0]       instr,
    output logic [SELW-1:0]  SEL_A,
    output logic [SELW-1:0]  SEL_B,
    input  logic [WIDTH-1:0] OUT_A,
    input  logic [WIDTH-1:0] OUT_B,
    output logic             write_en,
    output logic [SELW-1:0]  SEL_W,
    output logic [WIDTH-1:0] DATA_IN,
    output logic             carry,
    output logic             zero,
    output logic             done
);

    logic [1:0]       state;
    logic [7:0]       ir;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] alu_res;
    logic             alu_carry;
    logic             alu_zero;
    logic [1:0]       ir_op;
    logic             in_write;

    assign ir_op = ir[OP_MSB:OP_LSB];

    alu4 #(.WIDTH(WIDTH)) u_alu (
        .opa   (opa),
        .opb   (opb),
        .op    (ir_op),
        .res   (alu_res),
        .carry (alu_carry),
        .zero  (alu_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            ir     <= '0;
            opa    <= '0;
            opb    <= '0;
            result <= '0;
            carry  <= 1'b0;
            zero   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (instr_valid) begin
                        ir    <= instr;
                        state <= (instr[OP_MSB:OP_LSB] == OP_LDI) ? ST_WRITE : ST_READ;
                    end
                end
                ST_READ: begin
                    opa   <= OUT_A;
                    opb   <= OUT_B;
                    state <= ST_EXEC;
                end
                ST_EXEC: begin
                    result <= alu_res;
                    carry  <= alu_carry;
                    zero   <= alu_zero;
                    state  <= ST_WRITE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Write strobes decode from state alone, so async reset kills them at once.
    assign in_write    = (state == ST_WRITE);
    assign instr_ready = (state == ST_IDLE);
    assign write_en    = in_write;
    assign done        = in_write;
    assign SEL_A       = SELW'(ir[RA_MSB:RA_LSB]);
    assign SEL_B       = SELW'(ir[RB_MSB:RB_LSB]);
    assign SEL_W       = in_write ? SELW'(ir[RD_MSB:RD_LSB]) : '0;
    assign DATA_IN     = !in_write            ? '0 :
                         (ir_op == OP_LDI)    ? WIDTH'(ir[IMM_MSB:IMM_LSB]) :
                                                result;

endmodule

// File: tb/tb_regfile_sequencer.sv
// Directed bench: sequencer paired with a behavioural 4x4 register file.
module tb_regfile_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       instr_valid = 1'b0;
    logic       instr_ready;
    logic [7:0] instr = 8'h00;
    logic [1:0] SEL_A, SEL_B, SEL_W;
    logic [3:0] OUT_A, OUT_B, DATA_IN;
    logic       write_en, carry, zero, done;

    logic [3:0] rf [4];
    int         n_chk = 0;
    int         n_pass = 0;
    int         wr_cnt = 0;

    always #5 clk = ~clk;

    regfile_sequencer #(.WIDTH(4), .SELW(2)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .SEL_A       (SEL_A),
        .SEL_B       (SEL_B),
        .OUT_A       (OUT_A),
        .OUT_B       (OUT_B),
        .write_en    (write_en),
        .SEL_W       (SEL_W),
        .DATA_IN     (DATA_IN),
        .carry       (carry),
        .zero        (zero),
        .done        (done)
    );

    // register file model: combinational reads, write on rising edge
    assign OUT_A = rf[SEL_A];
    assign OUT_B = rf[SEL_B];
    always @(posedge clk) begin
        if (write_en) begin
            rf[SEL_W] <= DATA_IN;
            wr_cnt    <= wr_cnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic chk_flags(input string tag, input logic c, input logic z);
        chk({tag, "_carry"}, carry, c);
        chk({tag, "_zero"}, zero, z);
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (!instr_ready && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_idle"}, instr_ready, 1);
    endtask

    // Issue one instruction, check selects, latency to done and write-back.
    task automatic do_instr(input string tag, input logic [7:0] i,
                            input int exp_lat, input logic [3:0] exp_data);
        int n;
        logic [1:0] rd;
        rd = i[5:4];
        @(negedge clk);
        instr = i;
        instr_valid = 1'b1;
        wait_idle({tag, "_pre"});
        @(negedge clk);
        instr_valid = 1'b0;
        chk({tag, "_busy"}, instr_ready, 0);
        chk({tag, "_sel_a"}, SEL_A, i[3:2]);
        chk({tag, "_sel_b"}, SEL_B, i[1:0]);
        n = 1;
        while (!done && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_lat"}, n, exp_lat);
        chk({tag, "_we"}, write_en, 1);
        chk({tag, "_sel_w"}, SEL_W, rd);
        chk({tag, "_data_in"}, DATA_IN, exp_data);
        @(negedge clk);
        chk({tag, "_done_off"}, done, 0);
        chk({tag, "_rf"}, rf[rd], exp_data);
        chk({tag, "_ready"}, instr_ready, 1);
    endtask

    // Hold instr_valid high across two instructions; return gap between accepts.
    task automatic pair(input logic [7:0] i1, input logic [7:0] i2, output int gap);
        int t1 = -1;
        int t2 = -1;
        @(negedge clk);
        instr = i1;
        instr_valid = 1'b1;
        for (int n = 0; n < 20; n++) begin
            if (instr_valid && instr_ready) begin
                if (t1 < 0) t1 = n;
                else t2 = n;
            end
            @(negedge clk);
            if (t2 >= 0) break;
            if (t1 >= 0) instr = i2;
        end
        instr_valid = 1'b0;
        gap = t2 - t1;
    endtask

    initial begin
        int gap;
        int wr_snap;

        // reset state
        #12;
        chk("rst_ready", instr_ready, 1);
        chk("rst_we", write_en, 0);
        chk("rst_done", done, 0);
        chk("rst_sel_w", SEL_W, 0);
        chk("rst_data_in", DATA_IN, 0);
        chk_flags("rst", 0, 0);
        @(negedge clk);
        rst_n = 1'b1;

        do_instr("ldi_r1_5", 8'hD5, 1, 4'h5);
        chk_flags("ldi_r1_5", 0, 0);
        do_instr("ldi_r2_c", 8'hEC, 1, 4'hC);
        do_instr("add_r3", 8'h36, 3, 4'h1);          // 5 + C = 0x11
        chk_flags("add_r3", 1, 0);
        do_instr("sub_r0_r1r1", 8'h45, 3, 4'h0);
        chk_flags("sub_r0_r1r1", 1, 1);
        do_instr("ldi_r2_3", 8'hE3, 1, 4'h3);
        chk_flags("ldi_keeps", 1, 1);
        do_instr("sub_wrap", 8'h49, 3, 4'hE);        // 3 - 5 = -2 mod 16
        chk_flags("sub_wrap", 0, 0);
        do_instr("ldi_r2_f", 8'hEF, 1, 4'hF);
        do_instr("nand_r2", 8'hAA, 3, 4'h0);
        chk_flags("nand_r2", 0, 1);

        // back-to-back dependent: LDI r1 #3 then ADD r1,r1,r1
        pair(8'hD3, 8'h15, gap);
        chk("b2b_gap", gap, 2);
        wait_idle("b2b");
        chk("b2b_r1", rf[1], 4'h6);
        chk_flags("b2b", 0, 0);

        do_instr("sub_set_flags", 8'h45, 3, 4'h0);
        chk_flags("sub_set_flags", 1, 1);

        // reset during EXEC of ADD r3,r1,r2 (would write 6)
        wr_snap = wr_cnt;
        @(negedge clk);
        instr = 8'h36;
        instr_valid = 1'b1;
        @(negedge clk);
        instr_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_we", write_en, 0);
        chk("mid_rst_ready", instr_ready, 1);
        chk_flags("mid_rst", 0, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("mid_rst_no_write", wr_cnt, wr_snap);
        chk("mid_rst_r3", rf[3], 4'h1);
        do_instr("post_rst_ldi", 8'hF9, 1, 4'h9);

        // valid held while busy: LDI r0 #7 must wait for IDLE
        pair(8'h35, 8'hC7, gap);
        chk("busy_gap", gap, 4);
        wait_idle("busy");
        chk("busy_r3", rf[3], 4'hC);
        chk("busy_r0", rf[0], 4'h7);
        chk_flags("busy", 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
